// File: rtl/gcd_req_pkg.sv
// rtl/gcd_req_pkg.sv - shared state encoding and default constants for the gcd requester
package gcd_req_pkg;

  localparam int GCD_REQ_WIDTH      = 8;
  localparam int GCD_REQ_WDOG_LIMIT = 64;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } gcd_req_state_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// rtl/gcd_req_fifo.sv - request FIFO holding {a, b} operand pairs
module gcd_req_fifo
  import gcd_req_pkg::*;
#(
  parameter int W     = 2 * GCD_REQ_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/gcd_requester.sv
// rtl/gcd_requester.sv - start/busy initiator for the gcd unit; watchdog built with GCD_REQ_WDOG_EN
module gcd_requester
  import gcd_req_pkg::*;
#(
  parameter int N     = GCD_REQ_WIDTH,
  parameter int DEPTH = 2
`ifdef GCD_REQ_WDOG_EN
  ,
  parameter int WDOG_LIMIT = GCD_REQ_WDOG_LIMIT
`endif
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_a,
  output logic [N-1:0] res_b,
  output logic [N-1:0] res_gcd,
  output logic         gcd_start,
  output logic [N-1:0] gcd_a,
  output logic [N-1:0] gcd_b,
  input  logic         gcd_busy,
  input  logic [N-1:0] gcd_o,
  output logic         wdog_err
);

  gcd_req_state_e state;
  logic [2*N-1:0] fifo_rd_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           slot_free;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign slot_free = !res_valid || res_ready;
  assign pop       = (state == ST_IDLE) && !fifo_empty && slot_free;

  gcd_req_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({req_a, req_b}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // gcd itself has no reset, so SYNC drains any orphan job before issuing.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SYNC;
      gcd_start <= 1'b0;
      gcd_a     <= '0;
      gcd_b     <= '0;
      res_valid <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      res_gcd   <= '0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (!gcd_busy) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (pop) begin
            gcd_a     <= fifo_rd_data[2*N-1:N];
            gcd_b     <= fifo_rd_data[N-1:0];
            gcd_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          gcd_start <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!gcd_busy) begin
            res_gcd   <= gcd_o;
            res_a     <= gcd_a;
            res_b     <= gcd_b;
            res_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

`ifdef GCD_REQ_WDOG_EN
  localparam int WCW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WCW-1:0] WDOG_MAX  = WCW'(WDOG_LIMIT);
  localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_LIMIT - 1);

  logic [WCW-1:0] wdog_cnt;
  logic           wdog_q;

  // Counter saturates at the limit; the error flag is sticky until reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_q   <= 1'b0;
    end else if (state == ST_ISSUE) begin
      wdog_cnt <= '0;
    end else if ((state == ST_WAIT) && gcd_busy && (wdog_cnt != WDOG_MAX)) begin
      wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt == WDOG_LAST) wdog_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_requester.sv
// tb/tb_gcd_requester.sv - directed bench for gcd_requester with a behavioural gcd unit
`timescale 1ns/1ps
module tb_gcd_requester;

  localparam int N          = 8;
  localparam int DEPTH      = 2;
  localparam int WDOG_LIMIT = 64;
`ifdef GCD_REQ_WDOG_EN
  localparam logic WDOG_EXP = 1'b1;
`else
  localparam logic WDOG_EXP = 1'b0;
`endif

  logic         clock     = 1'b0;
  logic         rst_n     = 1'b0;
  logic         req_valid = 1'b0;
  logic         res_ready = 1'b0;
  logic [N-1:0] req_a     = '0;
  logic [N-1:0] req_b     = '0;
  logic         req_ready;
  logic         res_valid;
  logic         gcd_start;
  logic         wdog_err;
  logic [N-1:0] res_a, res_b, res_gcd, gcd_a, gcd_b;
  logic         gcd_busy = 1'b0;
  logic [N-1:0] gcd_o    = '0;
  logic         stuck    = 1'b0;
  logic [N-1:0] gx = '0;
  logic [N-1:0] gy = '0;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit double_start = 1'b0;
  logic prev_start = 1'b0;
  logic [3*N-1:0] res_q[$];

  always #5 clock = ~clock;

  gcd_requester #(.N(N), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_a     (res_a),
    .res_b     (res_b),
    .res_gcd   (res_gcd),
    .gcd_start (gcd_start),
    .gcd_a     (gcd_a),
    .gcd_b     (gcd_b),
    .gcd_busy  (gcd_busy),
    .gcd_o     (gcd_o),
    .wdog_err  (wdog_err)
  );

  // Subtractive gcd unit without reset; reports 0 when either operand is 0.
  always @(posedge clock) begin
    if (gcd_start) begin
      gx       <= gcd_a;
      gy       <= gcd_b;
      gcd_busy <= 1'b1;
    end else if (gcd_busy && !stuck) begin
      if (gx == 0 || gy == 0) begin
        gcd_o    <= '0;
        gcd_busy <= 1'b0;
      end else if (gx == gy) begin
        gcd_o    <= gx;
        gcd_busy <= 1'b0;
      end else if (gx > gy) begin
        gx <= gx - gy;
      end else begin
        gy <= gy - gx;
      end
    end
  end

  always @(posedge clock) begin
    if (rst_n && res_valid && res_ready) res_q.push_back({res_gcd, res_a, res_b});
    if (gcd_start) begin
      start_cnt++;
      if (prev_start) double_start = 1'b1;
    end
    prev_start = gcd_start;
  end

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    while (!req_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout req_ready got %b want 1", req_ready);
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_results(input int cnt, input int limit);
    int n = 0;
    while (res_q.size() < cnt && n < limit) begin
      @(negedge clock);
      n++;
    end
    if (res_q.size() < cnt) begin
      checks++; errors++;
      $display("FAIL result_timeout got %0d results want %0d", res_q.size(), cnt);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_a !== 8'd0) begin errors++; $display("FAIL reset_res_a got %0d want 0", res_a); end
    checks++; if (res_b !== 8'd0) begin errors++; $display("FAIL reset_res_b got %0d want 0", res_b); end
    checks++; if (res_gcd !== 8'd0) begin errors++; $display("FAIL reset_res_gcd got %0d want 0", res_gcd); end
    checks++; if (gcd_start !== 1'b0) begin errors++; $display("FAIL reset_gcd_start got %b want 0", gcd_start); end
    checks++; if (gcd_a !== 8'd0 || gcd_b !== 8'd0) begin errors++; $display("FAIL reset_gcd_ab got %0d,%0d want 0,0", gcd_a, gcd_b); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog_err got %b want 0", wdog_err); end
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_single();
    logic [3*N-1:0] r;
    res_ready = 1'b1;
    res_q.delete();
    start_cnt = 0;
    double_start = 1'b0;
    push(8'd12, 8'd18);
    checks++; if (gcd_start !== 1'b0) begin errors++; $display("FAIL single_start_early got %b want 0", gcd_start); end
    @(negedge clock);
    checks++; if (gcd_start !== 1'b1) begin errors++; $display("FAIL single_start_rise got %b want 1", gcd_start); end
    @(negedge clock);
    checks++; if (gcd_start !== 1'b0) begin errors++; $display("FAIL single_start_width got %b want 0", gcd_start); end
    wait_results(1, 100);
    repeat (5) @(negedge clock);
    r = (res_q.size() > 0) ? res_q[0] : 'x;
    checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", res_q.size()); end
    checks++; if (r !== {8'd6, 8'd12, 8'd18}) begin errors++; $display("FAIL single_result got gcd=%0d a=%0d b=%0d want 6,12,18", r[23:16], r[15:8], r[7:0]); end
    checks++; if (start_cnt !== 1 || double_start !== 1'b0) begin errors++; $display("FAIL single_start_count got %0d dbl=%b want 1 dbl=0", start_cnt, double_start); end
    checks++; if (gcd_a !== 8'd12 || gcd_b !== 8'd18) begin errors++; $display("FAIL single_gcd_ab_hold got %0d,%0d want 12,18", gcd_a, gcd_b); end
  endtask

  task automatic test_back_to_back();
    logic [3*N-1:0] r;
    logic [3*N-1:0] exp_r [3];
    exp_r[0] = {8'd6, 8'd12, 8'd18};
    exp_r[1] = {8'd7, 8'd35, 8'd21};
    exp_r[2] = {8'd0, 8'd0, 8'd5};
    res_ready = 1'b0;
    res_q.delete();
    start_cnt = 0;
    double_start = 1'b0;
    push(8'd12, 8'd18);
    push(8'd35, 8'd21);
    push(8'd0, 8'd5);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got req_ready=%b want 0", req_ready); end
    repeat (20) @(negedge clock);
    checks++; if (start_cnt !== 1) begin errors++; $display("FAIL b2b_blocked_issue got %0d starts want 1", start_cnt); end
    checks++; if (res_valid !== 1'b1 || res_gcd !== 8'd6) begin errors++; $display("FAIL b2b_held got valid=%b gcd=%0d want 1,6", res_valid, res_gcd); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_full got %b want 0", req_ready); end
    res_ready = 1'b1;
    wait_results(3, 300);
    repeat (5) @(negedge clock);
    checks++; if (res_q.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", res_q.size()); end
    for (int i = 0; i < 3; i++) begin
      r = (i < res_q.size()) ? res_q[i] : 'x;
      checks++;
      if (r !== exp_r[i]) begin
        errors++;
        $display("FAIL b2b_result%0d got %0d,%0d,%0d want %0d,%0d,%0d", i, r[23:16], r[15:8], r[7:0], exp_r[i][23:16], exp_r[i][15:8], exp_r[i][7:0]);
      end
    end
    checks++; if (start_cnt !== 3 || double_start !== 1'b0) begin errors++; $display("FAIL b2b_starts got %0d dbl=%b want 3 dbl=0", start_cnt, double_start); end
  endtask

  task automatic test_same_edge();
    logic [3*N-1:0] r;
    logic [3*N-1:0] exp_r [4];
    exp_r[0] = {8'd4, 8'd8, 8'd12};
    exp_r[1] = {8'd7, 8'd7, 8'd7};
    exp_r[2] = {8'd25, 8'd100, 8'd75};
    exp_r[3] = {8'd1, 8'd1, 8'd1};
    res_ready = 1'b1;
    res_q.delete();
    start_cnt = 0;
    double_start = 1'b0;
    push(8'd8, 8'd12);
    push(8'd7, 8'd7);
    push(8'd100, 8'd75);
    push(8'd1, 8'd1);
    wait_results(4, 400);
    repeat (10) @(negedge clock);
    checks++; if (res_q.size() !== 4) begin errors++; $display("FAIL same_edge_count got %0d want 4", res_q.size()); end
    for (int i = 0; i < 4; i++) begin
      r = (i < res_q.size()) ? res_q[i] : 'x;
      checks++;
      if (r !== exp_r[i]) begin
        errors++;
        $display("FAIL same_edge_result%0d got %0d,%0d,%0d want %0d,%0d,%0d", i, r[23:16], r[15:8], r[7:0], exp_r[i][23:16], exp_r[i][15:8], exp_r[i][7:0]);
      end
    end
    checks++; if (start_cnt !== 4 || double_start !== 1'b0) begin errors++; $display("FAIL same_edge_starts got %0d dbl=%b want 4 dbl=0", start_cnt, double_start); end
  endtask

  task automatic test_reset_mid_job();
    logic [3*N-1:0] r;
    int n = 0;
    bit bad_start = 1'b0;
    bit stale = 1'b0;
    res_ready = 1'b1;
    push(8'd255, 8'd1);
    while (!gcd_busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++; if (gcd_busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_timeout got %b want 1", gcd_busy); end
    repeat (3) @(negedge clock);
    rst_n = 1'b0;
    #1;
    checks++; if (gcd_start !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midreset_async got start=%b valid=%b ready=%b want 0,0,1", gcd_start, res_valid, req_ready); end
    res_q.delete();
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    push(8'd9, 8'd6);
    n = 0;
    while (gcd_busy && n < 400) begin
      if (gcd_start) bad_start = 1'b1;
      if (res_valid) stale = 1'b1;
      @(negedge clock);
      n++;
    end
    checks++; if (gcd_busy !== 1'b0) begin errors++; $display("FAIL midreset_drain_timeout got busy=%b want 0", gcd_busy); end
    checks++; if (bad_start !== 1'b0) begin errors++; $display("FAIL midreset_sync_start got %b want 0", bad_start); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midreset_stale_valid got %b want 0", stale); end
    wait_results(1, 100);
    repeat (10) @(negedge clock);
    r = (res_q.size() > 0) ? res_q[0] : 'x;
    checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL midreset_count got %0d want 1", res_q.size()); end
    checks++; if (r !== {8'd3, 8'd9, 8'd6}) begin errors++; $display("FAIL midreset_result got %0d,%0d,%0d want 3,9,6", r[23:16], r[15:8], r[7:0]); end
  endtask

  task automatic test_watchdog();
    logic [3*N-1:0] r;
    int n = 0;
    res_ready = 1'b1;
    res_q.delete();
    stuck = 1'b1;
    push(8'd4, 8'd6);
    while (!gcd_start && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++; if (gcd_start !== 1'b1) begin errors++; $display("FAIL wdog_start_timeout got %b want 1", gcd_start); end
    repeat (WDOG_LIMIT) @(negedge clock);
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_early got %b want 0", wdog_err); end
    @(negedge clock);
    checks++; if (wdog_err !== WDOG_EXP) begin errors++; $display("FAIL wdog_rise got %b want %b", wdog_err, WDOG_EXP); end
    repeat (10) @(negedge clock);
    checks++; if (wdog_err !== WDOG_EXP) begin errors++; $display("FAIL wdog_sticky got %b want %b", wdog_err, WDOG_EXP); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL wdog_no_abort got valid=%b want 0", res_valid); end
    stuck = 1'b0;
    wait_results(1, 50);
    repeat (3) @(negedge clock);
    r = (res_q.size() > 0) ? res_q[0] : 'x;
    checks++; if (r !== {8'd2, 8'd4, 8'd6}) begin errors++; $display("FAIL wdog_late_result got %0d,%0d,%0d want 2,4,6", r[23:16], r[15:8], r[7:0]); end
    checks++; if (wdog_err !== WDOG_EXP) begin errors++; $display("FAIL wdog_after_done got %b want %b", wdog_err, WDOG_EXP); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_same_edge();
    test_reset_mid_job();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached time %0t want earlier finish", $time);
    $fatal(1);
  end

endmodule
